jt51_mixacc: RTL and testbench
==============================

# jt51_mixacc

Output mixer/accumulator directly downstream of the FM operator pipeline. Consumes one signed 14-bit operator output per clock, already zeroed for non-carrier slots by the operator stage. Routes each value to the left and/or right sum according to the slot's channel pan bits and accumulates a full 32-slot round (8 channels × 4 operators). At each round boundary it emits one saturated signed 16-bit stereo sample with a strobe and clip flags.

## Interface
Parameters:
- SHIFT, 0, arithmetic right shift applied to each 19-bit round sum before saturation to 16 bits (legal 0..3)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- zero  in  1  high in the cycle carrying slot 0 of a new round
- op_out  in  14  signed operator output for the current slot
- rl  in  2  pan of the current slot's channel, aligned with op_out; rl[0]=left enable, rl[1]=right enable
- left  out  16  signed left sample
- right  out  16  signed right sample
- sample  out  1  one-cycle strobe: left/right just updated
- clip_l  out  1  left sample of this strobe was saturated; valid while sample=1
- clip_r  out  1  right sample of this strobe was saturated; valid while sample=1
- round_err  out  1  sticky: a round of length other than 32 was detected

## Operation
- Two signed 19-bit accumulators, acc_l and acc_r.
- Per-cycle contributions: add_l = rl[0] ? sign-extended op_out : 0; add_r likewise with rl[1].
- Non-zero cycles: acc_x <= sat19(acc_x + add_x).
  - Saturating add clamps to [-262144, 262143].
  - Cannot trigger with 32-slot rounds (max |sum| 32×8192 = 262144). Guards against malformed long rounds.
- zero cycle:
  - acc_x <= add_x, restarting the round with slot 0.
  - The completed sum s = acc_x >>> SHIFT is saturated to [-32768, 32767] and registered into left/right.
  - clip_x <= 1 if clamping occurred.
- Priming flag primed, cleared by reset, set at the first zero.
  - The first zero after reset only loads the accumulators. left/right/sample/clip are not updated, because that round is partial.
- Slot counter, 5 bits:
  - Resets to 0. Loads 1 on a zero cycle; otherwise increments and wraps 31→0.
  - On zero with primed=1 and counter≠0, set round_err. Counter=0 at zero means exactly 32 cycles since the previous zero. round_err is cleared only by rst.
  - The output sample is still produced on a mis-sized round.
- zero on consecutive cycles: each is a valid boundary. The 1-slot round produces a sample and sets round_err.

## Timing
- Reset values: left=0, right=0, sample=0, clip_l=0, clip_r=0, round_err=0, acc_l=acc_r=0, counter=0, primed=0.
- Reset is asynchronous. Asserting rst mid-round discards the partial round immediately. After release, the next zero is treated as the first.
- Latency:
  - The last slot of a round (cycle before zero) is in acc at the zero edge.
  - left/right/clip/sample change on the rising edge that samples zero=1 and are visible in the following cycle.
  - Slot 31 to output: 2 edges.
- sample is high for exactly one cycle per boundary: the cycle after the edge where zero=1 and primed=1. Otherwise low.
- clip_l/clip_r are registered alongside left/right. They hold their value until the next strobe; meaningful only with sample.
- left/right hold between strobes.
- No input backpressure; one slot is consumed every clock.

## Test plan
- Reset then zero every 32 cycles, op_out=100 all slots, rl=2'b11, SHIFT=0 → first boundary: no sample. Each later boundary: sample=1 for one cycle, left=right=3200, clip=0, round_err=0.
- Pan routing: op_out=-50 with rl=2'b01 on slots 0–15 and rl=2'b10 on slots 16–31 → left=-800, right=-800. Repeat with rl=2'b00 everywhere → left=right=0.
- Saturation: op_out=8191, rl=2'b11 all 32 slots, SHIFT=0 → sum 262112 → left=right=32767, clip_l=clip_r=1. SHIFT=3 → left=32764, clip=0. op_out=-8192 with SHIFT=0 → left=-32768, clip_l=1.
- Round length: zero after 31 slots, then normal 32-slot rounds → sample still pulses, round_err=1 and stays 1. Back-to-back zero → round_err=1.
- Reset mid-round: assert rst at slot 17 → all outputs 0 immediately. After release, first zero gives no sample. Second zero gives a sample equal to the sum of one full round only.
- Negative/mixed: alternate op_out=+1000/-999 per slot, rl=2'b11 → left=right=16 per round; verify sample spacing of exactly 32 cycles.

Source files
------------

// File: rtl/jt51_mixacc.sv
// Stereo mixer/accumulator for the FM operator stream: sums 32 slots per round
// into left/right, then emits one saturated 16-bit sample per round boundary.
module jt51_mixacc #(
  parameter int SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               zero,
  input  logic signed [13:0] op_out,
  input  logic        [1:0]  rl,
  output logic signed [15:0] left,
  output logic signed [15:0] right,
  output logic               sample,
  output logic               clip_l,
  output logic               clip_r,
  output logic               round_err
);

  logic signed [18:0] acc_l_q, acc_l_d;
  logic signed [18:0] acc_r_q, acc_r_d;
  logic        [4:0]  cnt_q, cnt_d;
  logic               primed_q, primed_d;
  logic signed [15:0] left_q, left_d;
  logic signed [15:0] right_q, right_d;
  logic               sample_q, sample_d;
  logic               clip_l_q, clip_l_d;
  logic               clip_r_q, clip_r_d;
  logic               round_err_q, round_err_d;

  logic signed [18:0] add_l, add_r;
  logic signed [18:0] sh_l, sh_r;
  logic signed [15:0] sat_l, sat_r;
  logic               ovf_l, ovf_r;

  // A 20-bit sum overflowed 19 bits when its top two bits disagree.
  function automatic logic signed [18:0] sat19(input logic signed [19:0] v);
    if (v[19] != v[18]) return v[19] ? 19'sh40000 : 19'sh3FFFF;
    return v[18:0];
  endfunction

  function automatic logic sat16_ovf(input logic signed [18:0] v);
    return !((v[18:15] == 4'b0000) || (v[18:15] == 4'b1111));
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
    if (sat16_ovf(v)) return v[18] ? 16'sh8000 : 16'sh7FFF;
    return v[15:0];
  endfunction

  always_comb begin
    add_l = rl[0] ? {{5{op_out[13]}}, op_out} : 19'sd0;
    add_r = rl[1] ? {{5{op_out[13]}}, op_out} : 19'sd0;
    sh_l  = acc_l_q >>> SHIFT;
    sh_r  = acc_r_q >>> SHIFT;
    sat_l = sat16(sh_l);
    sat_r = sat16(sh_r);
    ovf_l = sat16_ovf(sh_l);
    ovf_r = sat16_ovf(sh_r);
  end

  always_comb begin
    acc_l_d     = sat19({acc_l_q[18], acc_l_q} + {add_l[18], add_l});
    acc_r_d     = sat19({acc_r_q[18], acc_r_q} + {add_r[18], add_r});
    cnt_d       = cnt_q + 5'd1;
    primed_d    = primed_q;
    left_d      = left_q;
    right_d     = right_q;
    sample_d    = 1'b0;
    clip_l_d    = clip_l_q;
    clip_r_d    = clip_r_q;
    round_err_d = round_err_q;
    if (zero) begin
      acc_l_d  = add_l;
      acc_r_d  = add_r;
      cnt_d    = 5'd1;
      primed_d = 1'b1;
      // The first boundary after reset closes a partial round, so it only primes.
      if (primed_q) begin
        left_d   = sat_l;
        right_d  = sat_r;
        clip_l_d = ovf_l;
        clip_r_d = ovf_r;
        sample_d = 1'b1;
        if (cnt_q != 5'd0) round_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      sample_q    <= 1'b0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
      round_err_q <= 1'b0;
    end else begin
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      left_q      <= left_d;
      right_q     <= right_d;
      sample_q    <= sample_d;
      clip_l_q    <= clip_l_d;
      clip_r_q    <= clip_r_d;
      round_err_q <= round_err_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign sample    = sample_q;
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign round_err = round_err_q;

endmodule

// File: tb/tb_jt51_mixacc.sv
// Scoreboard bench for jt51_mixacc: two instances (SHIFT=0 and SHIFT=3) share
// the input stream; a round-level model predicts each stereo sample.
module tb_jt51_mixacc;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               zero = 1'b0;
  logic signed [13:0] op_out = '0;
  logic        [1:0]  rl = 2'b00;

  logic signed [15:0] left0, right0, left3, right3;
  logic               sample0, clip_l0, clip_r0, round_err0;
  logic               sample3, clip_l3, clip_r3, round_err3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int l;
    int r;
    bit cl;
    bit cr;
    bit err;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  // Reference model state: plain round sums and slot bookkeeping.
  int sum_l = 0, sum_r = 0, slots = 0;
  bit primed = 0, err = 0;

  jt51_mixacc #(.SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .zero(zero), .op_out(op_out), .rl(rl),
    .left(left0), .right(right0), .sample(sample0),
    .clip_l(clip_l0), .clip_r(clip_r0), .round_err(round_err0)
  );

  jt51_mixacc #(.SHIFT(3)) u_dut3 (
    .clk(clk), .rst(rst), .zero(zero), .op_out(op_out), .rl(rl),
    .left(left3), .right(right3), .sample(sample3),
    .clip_l(clip_l3), .clip_r(clip_r3), .round_err(round_err3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic exp_t predict(input int sh);
    exp_t e;
    int   sl, sr;
    sl    = sum_l >>> sh;
    sr    = sum_r >>> sh;
    e.l   = clamp(sl, -32768, 32767);
    e.r   = clamp(sr, -32768, 32767);
    e.cl  = (e.l != sl);
    e.cr  = (e.r != sr);
    e.err = err;
    e.cyc = cyc + 1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Compares one instance's strobe against the head of its expectation queue.
  task automatic checkSample(input string tag, input int which, input logic s,
                             input int l, input int r, input logic cl,
                             input logic cr, input logic er);
    exp_t e;
    int   n;
    n = (which == 0) ? q0.size() : q3.size();
    if (s) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s.sample: got unexpected strobe, expected none (cycle %0d)", tag, cyc);
      end else begin
        e = (which == 0) ? q0.pop_front() : q3.pop_front();
        checkOutput({tag, ".cycle"}, cyc, e.cyc);
        checkOutput({tag, ".left"}, l, e.l);
        checkOutput({tag, ".right"}, r, e.r);
        checkOutput({tag, ".clip_l"}, int'(cl), int'(e.cl));
        checkOutput({tag, ".clip_r"}, int'(cr), int'(e.cr));
        checkOutput({tag, ".round_err"}, int'(er), int'(e.err));
      end
    end else if (n > 0) begin
      e = (which == 0) ? q0[0] : q3[0];
      if (e.cyc <= cyc) begin
        if (which == 0) void'(q0.pop_front()); else void'(q3.pop_front());
        checks++;
        errors++;
        $display("[TB] FAIL %s.sample: got no strobe, expected one at cycle %0d", tag, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkSample("shift0", 0, sample0, left0, right0, clip_l0, clip_r0, round_err0);
      checkSample("shift3", 3, sample3, left3, right3, clip_l3, clip_r3, round_err3);
    end
  end

  // Drives one slot and advances the round-level model before the edge.
  task automatic applyStimulus(input int op, input logic [1:0] pan, input bit z);
    int al, ar;
    op_out = 14'(op);
    rl     = pan;
    zero   = z;
    al     = pan[0] ? op : 0;
    ar     = pan[1] ? op : 0;
    if (z) begin
      if (primed) begin
        if (slots % 32 != 0) err = 1;
        q0.push_back(predict(0));
        q3.push_back(predict(3));
      end
      sum_l  = al;
      sum_r  = ar;
      slots  = 1;
      primed = 1;
    end else begin
      sum_l = clamp(sum_l + al, -262144, 262143);
      sum_r = clamp(sum_r + ar, -262144, 262143);
      slots++;
    end
    @(posedge clk);
    #1;
  endtask

  // Modes: 0 constant on both sides, 1 left/right split, 2 muted,
  // 3 alternating +1000/-999, 4 random values and pans.
  task automatic doRound(input int n, input int mode, input int val);
    int         op;
    logic [1:0] pan;
    for (int i = 0; i < n; i++) begin
      op  = val;
      pan = 2'b11;
      case (mode)
        1: pan = (i < 16) ? 2'b01 : 2'b10;
        2: pan = 2'b00;
        3: op  = (i % 2 == 0) ? 1000 : -999;
        4: begin
          op  = int'($urandom_range(0, 16383)) - 8192;
          pan = 2'($urandom_range(0, 3));
        end
        default: ;
      endcase
      applyStimulus(op, pan, i == 0);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".left0"}, left0, 0);
    checkOutput({tag, ".right0"}, right0, 0);
    checkOutput({tag, ".left3"}, left3, 0);
    checkOutput({tag, ".sample"}, int'(sample0 | sample3), 0);
    checkOutput({tag, ".clip"}, int'(clip_l0 | clip_r0 | clip_l3 | clip_r3), 0);
    checkOutput({tag, ".round_err"}, int'(round_err0 | round_err3), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) doRound(32, 0, 100);
    doRound(32, 1, -50);
    doRound(32, 2, -50);
    doRound(32, 0, 8191);
    doRound(32, 0, -8192);
    for (int i = 0; i < 3; i++) doRound(32, 3, 0);
    for (int i = 0; i < 4; i++) doRound(32, 4, 0);

    doRound(31, 0, 100);
    doRound(32, 0, 100);
    doRound(32, 4, 0);
    doRound(1, 0, 77);
    doRound(32, 0, 100);
    doRound(32, 0, 100);

    // Reset lands asynchronously in the middle of slot 17 of a round.
    doRound(17, 0, 100);
    #1;
    rst = 1'b1;
    #1;
    checkIdle("midreset");
    checkOutput("midreset.pending0", q0.size(), 0);
    checkOutput("midreset.pending3", q3.size(), 0);
    sum_l  = 0;
    sum_r  = 0;
    slots  = 0;
    primed = 0;
    err    = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    doRound(20, 0, 300);
    doRound(32, 0, 250);
    doRound(32, 4, 0);
    applyStimulus(0, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 1'b0);

    checkOutput("drain.q0", q0.size(), 0);
    checkOutput("drain.q3", q3.size(), 0);
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
